// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encodings and flag-bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_LSL  = 3'b100;
  localparam logic [2:0] OP_ASR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int unsigned NUM_FLAGS = 3;
  localparam int unsigned FLAG_N    = 0;
  localparam int unsigned FLAG_V    = 1;
  localparam int unsigned FLAG_Z    = 2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] step_acc;

  assign step_acc = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = step_acc;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntW'(WIDTH - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // The product is presented combinationally during the final step so the parent can register it.
  assign done_o    = run_q && (cnt_q == CntW'(WIDTH - 1));
  assign product_o = step_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered result/flags and valid/ready handshake on both sides.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 is_mul;
  logic [ShW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_v;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_prod;
  logic [WIDTH-1:0]     load_res;
  logic [NUM_FLAGS-1:0] load_flags;

  assign shamt  = bin[ShW-1:0];
  assign is_mul = (MUL_EN != 0) && (op == OP_MUL);

  // Ready only when idle, or when the held result is being consumed this very cycle.
  assign in_ready = reset_n &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(
        .WIDTH (WIDTH)
      ) u_mul (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .start_i   (accept && is_mul),
        .a_i       (ain),
        .b_i       (bin),
        .done_o    (mul_done),
        .product_o (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // Single-cycle datapath plus flag generation for whichever result is about to be loaded.
  always_comb begin
    alu_res = ain;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_res = ain & bin;
      OP_NOTB: alu_res = ~bin;
      OP_LSL:  alu_res = ain << shamt;
      OP_ASR:  alu_res = $signed(ain) >>> shamt;
      default: alu_res = ain;
    endcase

    load_res           = mul_done ? mul_prod : alu_res;
    load_flags         = '0;
    load_flags[FLAG_Z] = (load_res == '0);
    load_flags[FLAG_V] = mul_done ? 1'b0 : alu_v;
    load_flags[FLAG_N] = load_res[WIDTH-1];
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (is_mul) begin
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_HOLD;
            res_d       = load_res;
            flags_d     = load_flags;
            out_valid_d = 1'b1;
          end
        end else if (state_q == ST_HOLD && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_HOLD;
          res_d       = load_res;
          flags_d     = load_flags;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = res_q;
  assign z         = flags_q[FLAG_Z];
  assign v         = flags_q[FLAG_V];
  assign n         = flags_q[FLAG_N];
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed spec vectors plus randomized ops against a plain model.
module tb_alu_seq;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op        = 3'd0;
  logic [15:0] ain       = 16'd0;
  logic [15:0] bin       = 16'd0;
  logic        in_ready, out_valid, z, v, n, busy;
  logic [15:0] result;
  logic [19:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = {out_valid, result, z, v, n};

  alu_seq #(
    .WIDTH  (16),
    .MUL_EN (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .v         (v),
    .n         (n),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed overflow judged by integer range, shifts by multiply / int arithmetic shift.
  function automatic logic [18:0] model(input logic [2:0] o, input logic [15:0] a,
                                        input logic [15:0] b);
    int sa, sb, s, sh;
    logic [31:0] p;
    logic [15:0] r;
    logic ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sh  = int'(b[3:0]);
    ovf = 1'b0;
    case (o)
      3'd0: begin s = sa + sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: begin p = 32'(a) * (32'd1 << sh); r = p[15:0]; end
      3'd5: begin s = sa >>> sh; r = 16'(s); end
      3'd6: begin p = 32'(a) * 32'(b); r = p[15:0]; end
      default: r = a;
    endcase
    return {r, (r == 16'd0), ovf, r[15]};
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] edges [4];
    edges[0] = 16'h0000; edges[1] = 16'h7FFF; edges[2] = 16'h8000; edges[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, obs} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {in_ready, busy, obs});
    end
    step();
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got %b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5];
    logic [15:0] as [5];
    logic [15:0] bs [5];
    logic [18:0] exp [5];
    ops[0] = 3'd0; as[0] = 16'h7FFF; bs[0] = 16'h0001; exp[0] = {16'h8000, 3'b011};
    ops[1] = 3'd1; as[1] = 16'h0005; bs[1] = 16'h0005; exp[1] = {16'h0000, 3'b100};
    ops[2] = 3'd1; as[2] = 16'h8000; bs[2] = 16'h0001; exp[2] = {16'h7FFF, 3'b010};
    ops[3] = 3'd5; as[3] = 16'h8000; bs[3] = 16'hFFF3; exp[3] = {16'hF000, 3'b001};
    ops[4] = 3'd4; as[4] = 16'h0001; bs[4] = 16'h000F; exp[4] = {16'h8000, 3'b001};
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = ops[i]; ain = as[i]; bin = bs[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d]: got %b required 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (obs !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL directed[%0d]: got %h required %h", i, obs, {1'b1, exp[i]});
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_drain[%0d]: got %b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] prev;
    logic [2:0]  o;
    out_ready = 1'b1;
    prev = '0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        checks++;
        if (obs !== {1'b1, prev}) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h required %h", k, obs, {1'b1, prev});
        end
      end
      if (k == 60) begin
        in_valid = 1'b0;
      end else begin
        o = 3'($urandom_range(0, 7));
        if (o == 3'd6) o = 3'd7;
        op = o; ain = pick(); bin = pick();
        in_valid = 1'b1;
        prev = model(op, ain, bin);
      end
      step();
    end
  endtask

  task automatic test_mul();
    logic [15:0] a, b;
    logic [18:0] exp;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin a = 16'h00FF; b = 16'h0101; end
      else begin a = pick(); b = pick(); end
      exp = model(3'd6, a, b);
      if (t == 0) exp = {16'hFFFF, 3'b001};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = 3'd6; ain = a; bin = b;
      step();
      for (int i = 0; i < 16; i++) begin
        // Garbage requests while busy must be ignored.
        in_valid = (i < 15);
        op = 3'($urandom_range(0, 5)); ain = 16'($urandom); bin = 16'($urandom);
        #1;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
          errors++;
          $display("FAIL mul_busy[%0d.%0d]: got %b required 100", t, i,
                   {busy, in_ready, out_valid});
        end
        step();
      end
      checks++;
      if ({busy, obs} !== {1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL mul_result[%0d]: got %h required %h", t, {busy, obs}, {1'b0, 1'b1, exp});
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    logic [18:0] exp;
    a = pick(); b = pick();
    exp = model(3'd2, a, b);
    in_valid = 1'b1; op = 3'd2; ain = a; bin = b;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op = 3'd0; ain = 16'($urandom); bin = 16'($urandom);
      #1;
      checks++;
      if ({in_ready, obs} !== {1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got %h required %h", i, {in_ready, obs},
                 {1'b0, 1'b1, exp});
      end
      step();
    end
    a = pick(); b = pick();
    exp = model(3'd0, a, b);
    out_ready = 1'b1;
    in_valid  = 1'b1; op = 3'd0; ain = a; bin = b;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_ready: got %b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, exp}) begin
      errors++;
      $display("FAIL backpressure_next: got %h required %h", obs, {1'b1, exp});
    end
    step();
  endtask

  task automatic test_reset_mid();
    // Mid-multiply abort.
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd6; ain = 16'h1234; bin = 16'h0057;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, obs} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: got %h required 0", {busy, in_ready, obs});
    end
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      checks++;
      if ({busy, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_mul_quiet[%0d]: got %b required 00", i, {busy, out_valid});
      end
    end
    // Mid-hold abort.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; ain = 16'h0001; bin = 16'h0001;
    step();
    in_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_hold: got %h required 0", obs);
    end
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold_quiet[%0d]: got %b required 0", i, out_valid);
      end
    end
    in_valid = 1'b1; op = 3'd1; ain = 16'h0003; bin = 16'h0005;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 16'hFFFE, 3'b001}) begin
      errors++;
      $display("FAIL reset_recover: got %h required %h", obs, {1'b1, 16'hFFFE, 3'b001});
    end
    step();
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
